// File: rtl/branch_condition_unit_if.sv
// ---------------------------------------------------------------------------
// branch_condition_unit_if
// Purpose : bundles the ALU flag stream and the branch request/resolution
//           signals that connect the ALU and fetch logic to the
//           branch_condition_unit.
// Signals :
//   alu_issue, flag_valid, flag_logic   ALU op tracking and flag qualifiers
//   zero/carry/sign/overflow_flag       ALU Z, C, S, V
//   flush                               abort outstanding branch request
//   br_valid, br_ready, br_cond,        branch request handshake
//   br_target
//   res_valid, res_taken, res_target    branch resolution result
//   status                              {Z,C,S,V} status register
//   err                                 pending counter over/underflow pulse
// Modports:
//   master : ALU / fetch side, drives requests and flags
//   slave  : the branch_condition_unit itself
// ---------------------------------------------------------------------------
interface branch_condition_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  alu_issue;
    logic                  flag_valid;
    logic                  flag_logic;
    logic                  zero_flag;
    logic                  carry_flag;
    logic                  sign_flag;
    logic                  overflow_flag;
    logic                  flush;
    logic                  br_valid;
    logic                  br_ready;
    logic [3:0]            br_cond;
    logic [ADDR_WIDTH-1:0] br_target;
    logic                  res_valid;
    logic                  res_taken;
    logic [ADDR_WIDTH-1:0] res_target;
    logic [3:0]            status;
    logic                  err;

    modport master (
        output alu_issue, flag_valid, flag_logic,
        output zero_flag, carry_flag, sign_flag, overflow_flag,
        output flush, br_valid, br_cond, br_target,
        input  br_ready, res_valid, res_taken, res_target, status, err
    );

    modport slave (
        input  alu_issue, flag_valid, flag_logic,
        input  zero_flag, carry_flag, sign_flag, overflow_flag,
        input  flush, br_valid, br_cond, br_target,
        output br_ready, res_valid, res_taken, res_target, status, err
    );
endinterface

// File: rtl/branch_condition_unit.sv
// ---------------------------------------------------------------------------
// branch_condition_unit
// Purpose : consumer end of the ALU flag interface. Latches Z/C/S/V into a
//           status register, counts flag-producing ALU ops still in flight,
//           and resolves conditional branch requests against the status
//           register once no flag writes are outstanding.
// Ports   :
//   clk      in   system clock, rising edge
//   n_reset  in   synchronous active-low reset
//   bus      slave modport of branch_condition_unit_if (flags, branch
//            request, resolution result, status, err)
// ---------------------------------------------------------------------------
module branch_condition_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int PEND_WIDTH = 2
) (
    input logic                    clk,
    input logic                    n_reset,
    branch_condition_unit_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

    state_t                state_q, state_d;
    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic [3:0]            status_q, status_d;
    logic [3:0]            cond_q, cond_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_taken_q, res_taken_d;
    logic [ADDR_WIDTH-1:0] res_target_q, res_target_d;
    logic                  err_q, err_d;
    logic                  cond_met;

    logic z_flag, c_flag, s_flag, v_flag;
    assign z_flag = status_q[3];
    assign c_flag = status_q[2];
    assign s_flag = status_q[1];
    assign v_flag = status_q[0];

    // Status register: Z and S always load on a completed op, but logic ops
    // leave C and V undefined at the ALU, so those keep their old value.
    always_comb begin
        status_d = status_q;
        if (bus.flag_valid) begin
            status_d[3] = bus.zero_flag;
            status_d[1] = bus.sign_flag;
            if (!bus.flag_logic) begin
                status_d[2] = bus.carry_flag;
                status_d[0] = bus.overflow_flag;
            end
        end
    end

    // Pending counter saturates at both ends; hitting either end raises a
    // one-cycle err pulse instead of wrapping.
    always_comb begin
        pend_d = pend_q;
        err_d  = 1'b0;
        unique case ({bus.alu_issue, bus.flag_valid})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    err_d = 1'b1;
                end else begin
                    pend_d = pend_q + PEND_ONE;
                end
            end
            2'b01: begin
                if (pend_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    pend_d = pend_q - PEND_ONE;
                end
            end
            default: begin
                pend_d = pend_q;
            end
        endcase
    end

    // Condition evaluation always uses the registered status, so a flag
    // write landing on the same edge is seen only by the next evaluation.
    always_comb begin
        cond_met = 1'b0;
        unique case (cond_q)
            4'd0:  cond_met = z_flag;
            4'd1:  cond_met = !z_flag;
            4'd2:  cond_met = c_flag;
            4'd3:  cond_met = !c_flag;
            4'd4:  cond_met = s_flag;
            4'd5:  cond_met = !s_flag;
            4'd6:  cond_met = v_flag;
            4'd7:  cond_met = !v_flag;
            4'd8:  cond_met = !c_flag && !z_flag;
            4'd9:  cond_met = c_flag || z_flag;
            4'd10: cond_met = (s_flag == v_flag);
            4'd11: cond_met = (s_flag != v_flag);
            4'd12: cond_met = !z_flag && (s_flag == v_flag);
            4'd13: cond_met = z_flag || (s_flag != v_flag);
            4'd14: cond_met = 1'b1;
            4'd15: cond_met = 1'b0;
            default: cond_met = 1'b0;
        endcase
    end

    // Request FSM: flush has priority over both acceptance and resolution.
    // res_taken/res_target hold between resolutions.
    always_comb begin
        state_d      = state_q;
        cond_d       = cond_q;
        target_d     = target_q;
        res_valid_d  = 1'b0;
        res_taken_d  = res_taken_q;
        res_target_d = res_target_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.br_valid) begin
                        cond_d   = bus.br_cond;
                        target_d = bus.br_target;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (pend_q == '0) begin
                        res_valid_d  = 1'b1;
                        res_taken_d  = cond_met;
                        res_target_d = target_q;
                        state_d      = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // All state registers share one synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            status_q     <= '0;
            cond_q       <= '0;
            target_q     <= '0;
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            res_target_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            status_q     <= status_d;
            cond_q       <= cond_d;
            target_q     <= target_d;
            res_valid_q  <= res_valid_d;
            res_taken_q  <= res_taken_d;
            res_target_q <= res_target_d;
            err_q        <= err_d;
        end
    end

    assign bus.br_ready   = (state_q == IDLE);
    assign bus.res_valid  = res_valid_q;
    assign bus.res_taken  = res_taken_q;
    assign bus.res_target = res_target_q;
    assign bus.status     = status_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_branch_condition_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_condition_unit
// Purpose : self-checking bench for branch_condition_unit. Directed
//           scenarios compare against hand-derived values; a randomized
//           phase compares every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_branch_condition_unit;

    localparam int ADDR_WIDTH = 32;
    localparam int PEND_WIDTH = 2;
    localparam int PEND_MAX   = (1 << PEND_WIDTH) - 1;

    logic clk;
    logic n_reset;
    int   checks;
    int   errors;

    branch_condition_unit_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    branch_condition_unit #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .PEND_WIDTH(PEND_WIDTH)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: flags as separate booleans, pending as a
    // plain integer, and a single "request outstanding" bit.
    bit        mz, mc, ms, mv;
    int        m_pend;
    bit        m_busy;
    bit [3:0]  m_cond;
    bit [31:0] m_target;
    bit        m_res_valid;
    bit        m_res_taken;
    bit [31:0] m_res_target;
    bit        m_err;

    // Conditions come in pairs: the odd code is the negation of the even one.
    function automatic bit cond_holds(input bit [3:0] cc, input bit z, input bit c,
                                      input bit s, input bit v);
        bit base;
        int pair;
        pair = int'(cc) / 2;
        case (pair)
            0:       base = z;
            1:       base = c;
            2:       base = s;
            3:       base = v;
            4:       base = !(c || z);
            5:       base = (s == v);
            6:       base = !z && (s == v);
            default: base = 1'b1;
        endcase
        return (cc % 2 == 1) ? !base : base;
    endfunction

    task automatic idle_inputs();
        bus.alu_issue     = 1'b0;
        bus.flag_valid    = 1'b0;
        bus.flag_logic    = 1'b0;
        bus.zero_flag     = 1'b0;
        bus.carry_flag    = 1'b0;
        bus.sign_flag     = 1'b0;
        bus.overflow_flag = 1'b0;
        bus.flush         = 1'b0;
        bus.br_valid      = 1'b0;
        bus.br_cond       = 4'd0;
        bus.br_target     = '0;
    endtask

    task automatic set_flags(input bit logic_op, input bit z, input bit c,
                             input bit s, input bit v);
        bus.flag_valid    = 1'b1;
        bus.flag_logic    = logic_op;
        bus.zero_flag     = z;
        bus.carry_flag    = c;
        bus.sign_flag     = s;
        bus.overflow_flag = v;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        bit        rst_n, iss, fv, fl, z, c, s, v, fsh, bv;
        bit [3:0]  cc;
        bit [31:0] tg;
        int        np;
        rst_n = n_reset;
        iss = bus.alu_issue;  fv = bus.flag_valid; fl = bus.flag_logic;
        z = bus.zero_flag;    c = bus.carry_flag;  s = bus.sign_flag;
        v = bus.overflow_flag; fsh = bus.flush;    bv = bus.br_valid;
        cc = bus.br_cond;     tg = bus.br_target;
        @(posedge clk);
        if (!rst_n) begin
            {mz, mc, ms, mv} = 4'b0;
            m_pend = 0; m_busy = 0; m_cond = 0; m_target = 0;
            m_res_valid = 0; m_res_taken = 0; m_res_target = 0; m_err = 0;
        end else begin
            m_res_valid = 0;
            m_err = 0;
            if (fsh) begin
                m_busy = 0;
            end else if (!m_busy && bv) begin
                m_busy = 1; m_cond = cc; m_target = tg;
            end else if (m_busy && m_pend == 0) begin
                m_res_valid  = 1;
                m_res_taken  = cond_holds(m_cond, mz, mc, ms, mv);
                m_res_target = m_target;
                m_busy       = 0;
            end
            np = m_pend + int'(iss) - int'(fv);
            if (np > PEND_MAX || np < 0) m_err = 1;
            else m_pend = np;
            if (fv) begin
                mz = z; ms = s;
                if (!fl) begin mc = c; mv = v; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        n_reset = 1'b0;
        tick();
        tick();
        checks++; if (bus.br_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_br_ready got %0b want 1", bus.br_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got %0b want 0", bus.res_valid); end
        checks++; if (bus.res_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_taken got %0b want 0", bus.res_taken); end
        checks++; if (bus.res_target !== 32'h0) begin errors++; $display("[TB] FAIL reset_res_target got %h want 0", bus.res_target); end
        checks++; if (bus.status !== 4'b0000) begin errors++; $display("[TB] FAIL reset_status got %b want 0000", bus.status); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b want 0", bus.err); end
        n_reset = 1'b1;
    endtask

    task automatic test_eq_branch();
        idle_inputs();
        set_flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.status !== 4'b1000) begin errors++; $display("[TB] FAIL eq_status got %b want 1000", bus.status); end
        idle_inputs();
        bus.br_valid = 1'b1; bus.br_cond = 4'd0; bus.br_target = 32'h100;
        tick();
        checks++; if (bus.br_ready !== 1'b0) begin errors++; $display("[TB] FAIL eq_br_ready_busy got %0b want 0", bus.br_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL eq_res_early got %0b want 0", bus.res_valid); end
        idle_inputs();
        tick();
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL eq_res_valid got %0b want 1", bus.res_valid); end
        checks++; if (bus.res_taken !== 1'b1) begin errors++; $display("[TB] FAIL eq_res_taken got %0b want 1", bus.res_taken); end
        checks++; if (bus.res_target !== 32'h100) begin errors++; $display("[TB] FAIL eq_res_target got %h want 100", bus.res_target); end
        checks++; if (bus.br_ready !== 1'b1) begin errors++; $display("[TB] FAIL eq_br_ready_back got %0b want 1", bus.br_ready); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL eq_res_pulse got %0b want 0", bus.res_valid); end
        checks++; if (bus.res_target !== 32'h100) begin errors++; $display("[TB] FAIL eq_target_hold got %h want 100", bus.res_target); end
    endtask

    task automatic test_pending_wait();
        idle_inputs();
        bus.alu_issue = 1'b1;
        tick();
        tick();
        idle_inputs();
        bus.br_valid = 1'b1; bus.br_cond = 4'd11; bus.br_target = 32'h200;
        tick();
        for (int i = 1; i <= 6; i++) begin
            idle_inputs();
            if (i == 3) set_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 5) set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            checks++;
            if (bus.res_valid !== (i == 6)) begin
                errors++;
                $display("[TB] FAIL pend_res_valid_cycle%0d got %0b want %0b", i, bus.res_valid, (i == 6));
            end
        end
        checks++; if (bus.res_taken !== 1'b0) begin errors++; $display("[TB] FAIL pend_res_taken got %0b want 0", bus.res_taken); end
        checks++; if (bus.res_target !== 32'h200) begin errors++; $display("[TB] FAIL pend_res_target got %h want 200", bus.res_target); end
        idle_inputs();
        tick();
    endtask

    task automatic test_logic_flags();
        idle_inputs();
        set_flags(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if (bus.status !== 4'b0101) begin errors++; $display("[TB] FAIL logic_setup_status got %b want 0101", bus.status); end
        set_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.status !== 4'b0111) begin errors++; $display("[TB] FAIL logic_status got %b want 0111", bus.status); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        idle_inputs();
        bus.alu_issue = 1'b1;
        tick();
        idle_inputs();
        bus.br_valid = 1'b1; bus.br_target = 32'h300;
        tick();
        checks++; if (bus.br_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %0b want 0", bus.br_ready); end
        idle_inputs();
        bus.flush = 1'b1;
        tick();
        checks++; if (bus.br_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %0b want 1", bus.br_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_res_valid got %0b want 0", bus.res_valid); end
        idle_inputs();
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_res_late got %0b want 0", bus.res_valid); end
        bus.br_valid = 1'b1; bus.flush = 1'b1;
        tick();
        checks++; if (bus.br_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_blocks_accept got %0b want 1", bus.br_ready); end
        idle_inputs();
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        bus.br_valid = 1'b1; bus.br_cond = 4'd14; bus.br_target = 32'h400;
        tick();
        idle_inputs();
        bus.flush = 1'b1;
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks_resolve got %0b want 0", bus.res_valid); end
        checks++; if (bus.res_target === 32'h400) begin errors++; $display("[TB] FAIL flush_target_updated got %h want not 400", bus.res_target); end
        idle_inputs();
        tick();
    endtask

    task automatic test_pend_overflow();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            bus.alu_issue = 1'b1;
            tick();
            checks++;
            if (bus.err !== (i == 4)) begin
                errors++;
                $display("[TB] FAIL ovf_err_issue%0d got %0b want %0b", i, bus.err, (i == 4));
            end
        end
        idle_inputs();
        tick();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_err_pulse got %0b want 0", bus.err); end
        for (int i = 1; i <= 4; i++) begin
            set_flags(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            tick();
            checks++;
            if (bus.err !== (i == 4)) begin
                errors++;
                $display("[TB] FAIL udf_err_fv%0d got %0b want %0b", i, bus.err, (i == 4));
            end
        end
        checks++; if (bus.status !== 4'b1111) begin errors++; $display("[TB] FAIL udf_status got %b want 1111", bus.status); end
        idle_inputs();
        bus.br_valid = 1'b1; bus.br_cond = 4'd9; bus.br_target = 32'h500;
        tick();
        idle_inputs();
        tick();
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL udf_pend_zero got %0b want 1", bus.res_valid); end
        checks++; if (bus.res_taken !== 1'b1) begin errors++; $display("[TB] FAIL udf_ls_taken got %0b want 1", bus.res_taken); end
    endtask

    task automatic test_reset_in_wait();
        idle_inputs();
        bus.alu_issue = 1'b1;
        tick();
        idle_inputs();
        bus.br_valid = 1'b1;
        tick();
        idle_inputs();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        checks++; if (bus.br_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstw_br_ready got %0b want 1", bus.br_ready); end
        checks++; if (bus.status !== 4'b0000) begin errors++; $display("[TB] FAIL rstw_status got %b want 0000", bus.status); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstw_res_valid got %0b want 0", bus.res_valid); end
        bus.br_valid = 1'b1; bus.br_cond = 4'd14; bus.br_target = 32'h600;
        tick();
        idle_inputs();
        tick();
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstw_pend_cleared got %0b want 1", bus.res_valid); end
        checks++; if (bus.res_target !== 32'h600) begin errors++; $display("[TB] FAIL rstw_target got %h want 600", bus.res_target); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            n_reset           = ($urandom % 64) != 0;
            bus.alu_issue     = ($urandom % 3) == 0;
            bus.flag_valid    = ($urandom % 3) == 0;
            bus.flag_logic    = $urandom % 2;
            bus.zero_flag     = $urandom % 2;
            bus.carry_flag    = $urandom % 2;
            bus.sign_flag     = $urandom % 2;
            bus.overflow_flag = $urandom % 2;
            bus.flush         = ($urandom % 16) == 0;
            bus.br_valid      = $urandom % 2;
            bus.br_cond       = 4'($urandom % 16);
            bus.br_target     = $urandom;
            tick();
            checks++; if (bus.br_ready !== !m_busy) begin errors++; $display("[TB] FAIL rnd%0d_br_ready got %0b want %0b", i, bus.br_ready, !m_busy); end
            checks++; if (bus.res_valid !== m_res_valid) begin errors++; $display("[TB] FAIL rnd%0d_res_valid got %0b want %0b", i, bus.res_valid, m_res_valid); end
            checks++; if (bus.res_taken !== m_res_taken) begin errors++; $display("[TB] FAIL rnd%0d_res_taken got %0b want %0b", i, bus.res_taken, m_res_taken); end
            checks++; if (bus.res_target !== m_res_target) begin errors++; $display("[TB] FAIL rnd%0d_res_target got %h want %h", i, bus.res_target, m_res_target); end
            checks++; if (bus.status !== {mz, mc, ms, mv}) begin errors++; $display("[TB] FAIL rnd%0d_status got %b want %b", i, bus.status, {mz, mc, ms, mv}); end
            checks++; if (bus.err !== m_err) begin errors++; $display("[TB] FAIL rnd%0d_err got %0b want %0b", i, bus.err, m_err); end
        end
        n_reset = 1'b1;
        idle_inputs();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        n_reset = 1'b0;
        idle_inputs();
        test_reset();
        test_eq_branch();
        test_pending_wait();
        test_logic_flags();
        test_flush();
        test_pend_overflow();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
